// File: rtl/ov7670_pkg.sv
// Shared types, geometry defaults and pixel helpers for the OV7670 capture path.
package ov7670_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2
  } cap_state_t;

  localparam int H_ACTIVE_DEF = 320;
  localparam int V_ACTIVE_DEF = 240;
  localparam int FRAME_PIXELS = H_ACTIVE_DEF * V_ACTIVE_DEF;

  // Line/row counters are wide enough to count past the active geometry.
  localparam int CNT_W = 12;

  // Colour bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // Widen each channel by replicating its top bits into the new LSBs.
  function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] pix);
    return {pix[15:11], pix[15:13], pix[10:5], pix[10:9], pix[4:0], pix[4:2]};
  endfunction

  function automatic logic [23:0] colour_bar(input logic [2:0] bar);
    return BAR_RGB[bar];
  endfunction

endpackage

// File: rtl/ov7670_byte_pair.sv
// Pairs consecutive HREF bytes into RGB565 pixels: the first byte of a pair is
// held as the high byte, the second completes the pixel. A dangling odd byte
// is lost when HREF drops.
module ov7670_byte_pair (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_href,
  input  logic [7:0]  i_d,
  output logic        o_pixel_valid,
  output logic [15:0] o_pixel
);

  logic       r_phase;
  logic [7:0] r_hi;

  // Toggle byte phase while HREF is high; hold the high byte on phase 0.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= 1'b0;
      r_hi    <= '0;
    end else if (i_clr || !i_href) begin
      r_phase <= 1'b0;
    end else begin
      r_phase <= ~r_phase;
      if (!r_phase) r_hi <= i_d;
    end
  end

  assign o_pixel_valid = i_href & r_phase;
  assign o_pixel       = {r_hi, i_d};

endmodule

// File: rtl/ov7670_pixel_capture.sv
// OV7670 RGB565 capture into a linear RGB888 frame-buffer write port.
// Optional build macro OV7670_CAPTURE_TEST_PATTERN_EN adds input test_mode,
// which replaces camera pixel values with eight vertical colour bars.
module ov7670_pixel_capture
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = $clog2(FRAME_PIXELS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_d,
  output logic [23:0]       data,
  output logic [ADDR_W-1:0] wraddress,
  output logic              wren,
  output logic              frame_done,
  output logic              geom_err
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
  ,
  input  logic              test_mode
`endif
);

  localparam logic [CNT_W-1:0] H_LIM = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_LIM = CNT_W'(V_ACTIVE);

  logic r_vsync, r_vsync_d, r_href, r_href_d, r_enable;
  logic [7:0] r_d;
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
  logic r_test_mode;
`endif

  cap_state_t r_state, w_state_nxt;
  logic w_capture_entry, w_frame_end;
  logic w_vs_rise, w_vs_fall, w_href_fall;
  logic w_pix_valid, w_write, w_line_open, w_geom_bad;
  logic [15:0] w_pixel;
  logic [23:0] w_pix_rgb;
  logic [CNT_W-1:0] r_col, r_row, w_rows_final;
  logic r_line_err;
  logic [ADDR_W-1:0] r_addr;

  logic [23:0] r_data;
  logic [ADDR_W-1:0] r_wraddress;
  logic r_wren, r_frame_done, r_geom_err;

  // Register the camera bus once; everything downstream sees only these copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync     <= 1'b0;
      r_vsync_d   <= 1'b0;
      r_href      <= 1'b0;
      r_href_d    <= 1'b0;
      r_enable    <= 1'b0;
      r_d         <= '0;
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
      r_test_mode <= 1'b0;
`endif
    end else begin
      r_vsync     <= cam_vsync;
      r_vsync_d   <= r_vsync;
      r_href      <= cam_href;
      r_href_d    <= r_href;
      r_enable    <= enable;
      r_d         <= cam_d;
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
      r_test_mode <= test_mode;
`endif
    end
  end

  assign w_vs_rise   = r_vsync & ~r_vsync_d;
  assign w_vs_fall   = ~r_vsync & r_vsync_d;
  assign w_href_fall = ~r_href & r_href_d;

  ov7670_byte_pair u_byte_pair (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clr         (w_capture_entry),
    .i_href        (r_href),
    .i_d           (r_d),
    .o_pixel_valid (w_pix_valid),
    .o_pixel       (w_pixel)
  );

  // Capture state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Frame sequencing: arm on VSYNC, start on its fall if enabled, end on its rise.
  // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_capture_entry = 1'b0;
    w_frame_end     = 1'b0;
    unique case (r_state)
      IDLE:    if (w_vs_rise) w_state_nxt = SYNC;
      SYNC:    if (w_vs_fall && r_enable) begin
                 w_state_nxt     = CAPTURE;
                 w_capture_entry = 1'b1;
               end
      CAPTURE: if (w_vs_rise) begin
                 w_state_nxt = SYNC;
                 w_frame_end = 1'b1;
               end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A pixel completing on the VSYNC rise belongs to a cut-off line and is dropped.
  assign w_write = (r_state == CAPTURE) && !w_vs_rise && w_pix_valid &&
                   (r_col < H_LIM) && (r_row < V_LIM);

  // A line still open at frame end counts as a row for the geometry check.
  assign w_line_open  = (r_col != '0);
  assign w_rows_final = r_row + CNT_W'(w_line_open);
  assign w_geom_bad   = r_line_err | (w_line_open & (r_col != H_LIM)) |
                        (w_rows_final != V_LIM);

`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
  assign w_pix_rgb = r_test_mode ? colour_bar(r_col[8:6]) : rgb565_to_rgb888(w_pixel);
`else
  assign w_pix_rgb = rgb565_to_rgb888(w_pixel);
`endif

  // Column, row, line-error and address bookkeeping for the frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col      <= '0;
      r_row      <= '0;
      r_line_err <= 1'b0;
      r_addr     <= '0;
    end else if (w_capture_entry) begin
      r_col      <= '0;
      r_row      <= '0;
      r_line_err <= 1'b0;
      r_addr     <= '0;
    end else if (r_state == CAPTURE) begin
      if (w_pix_valid && r_col != '1) r_col <= r_col + CNT_W'(1);
      if (w_href_fall) begin
        r_col <= '0;
        if (w_line_open) begin
          if (r_row != '1) r_row <= r_row + CNT_W'(1);
          if (r_col != H_LIM) r_line_err <= 1'b1;
        end
      end
      if (w_write) r_addr <= r_addr + ADDR_W'(1);
    end
  end

  // Frame-buffer write port and frame status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_wraddress  <= '0;
      r_wren       <= 1'b0;
      r_frame_done <= 1'b0;
      r_geom_err   <= 1'b0;
    end else begin
      r_wren       <= w_write;
      r_frame_done <= w_frame_end;
      if (w_write) begin
        r_data      <= w_pix_rgb;
        r_wraddress <= r_addr;
      end
      if (w_frame_end) r_geom_err <= w_geom_bad;
    end
  end

  assign data       = r_data;
  assign wraddress  = r_wraddress;
  assign wren       = r_wren;
  assign frame_done = r_frame_done;
  assign geom_err   = r_geom_err;

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Self-checking bench for ov7670_pixel_capture. Full 320-pixel lines are used,
// but frames are only 6 lines tall to keep the run short. Expected writes are
// derived per line from byte counts and the RGB565->RGB888 arithmetic.
`timescale 1ns/1ps
module tb_ov7670_pixel_capture;

  localparam int H   = 320;
  localparam int V   = 6;
  localparam int AW  = 17;
  localparam int GAP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          cam_vsync = 1'b0;
  logic          cam_href = 1'b0;
  logic [7:0]    cam_d = '0;
  logic [23:0]   data;
  logic [AW-1:0] wraddress;
  logic          wren, frame_done, geom_err;
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
  logic          test_mode = 1'b0;
`endif

  ov7670_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_d      (cam_d),
    .data       (data),
    .wraddress  (wraddress),
    .wren       (wren),
    .frame_done (frame_done),
    .geom_err   (geom_err)
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
    ,
    .test_mode  (test_mode)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [23:0]   data;
  } wr_t;

  wr_t        q_got[$];
  wr_t        q_exp[$];
  wr_t        mon_w;
  logic [7:0] fixed_bytes[$];

  int n_checks = 0, n_errors = 0;
  int fd_cnt = 0, fd_base = 0, exp_fd = 0, consec_cnt = 0;
  logic prev_wren = 1'b0;

  // Reference-model state at frame granularity.
  bit m_armed = 0, m_cap = 0, m_bad = 0, m_geom = 0, m_tp = 0;
  int m_row = 0, m_addr = 0, byte_cnt = 0, rst_byte = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Write-port monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (wren) begin
      mon_w.addr = wraddress;
      mon_w.data = data;
      q_got.push_back(mon_w);
    end
    if (wren && prev_wren) consec_cnt++;
    if (frame_done) fd_cnt++;
    prev_wren = wren;
  end

  function automatic logic [23:0] bar_rgb(input int bar);
    case (bar)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] model_rgb(input logic [7:0] hi, input logic [7:0] lo, input int col);
    int r5, g6, b5, r8, g8, b8;
    if (m_tp) return bar_rgb(col / 64);
    r5 = int'(hi) / 8;
    g6 = (int'(hi) % 8) * 8 + int'(lo) / 32;
    b5 = int'(lo) % 32;
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return 24'(r8 * 65536 + g8 * 256 + b8);
  endfunction

  function automatic logic [7:0] next_byte();
    if (fixed_bytes.size() > 0) return fixed_bytes.pop_front();
    return 8'($urandom);
  endfunction

  function automatic logic [23:0] got_data(input int i);
    if (i < q_got.size()) return q_got[i].data;
    return 'x;
  endfunction

  function automatic logic [AW-1:0] got_addr(input int i);
    if (i < q_got.size()) return q_got[i].addr;
    return 'x;
  endfunction

  task automatic apply_mid_reset();
    rst_n = 1'b0;
    #1;
    check("rst_mid_wren", wren, 1'b0);
    check("rst_mid_wraddress", wraddress, 0);
    check("rst_mid_frame_done", frame_done, 1'b0);
    check("rst_mid_geom_err", geom_err, 1'b0);
    q_got.delete();
    q_exp.delete();
    m_cap   = 0;
    m_armed = 0;
    m_geom  = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_byte(input logic [7:0] d);
    @(negedge clk);
    cam_href = 1'b1;
    cam_d    = d;
    if (byte_cnt == rst_byte) apply_mid_reset();
    byte_cnt++;
  endtask

  // One HREF line of nbytes; keep_high leaves HREF asserted for a cut-off line.
  task automatic send_line(input int nbytes, input bit keep_high);
    int pix = 0;
    logic [7:0] hi = '0;
    logic [7:0] d;
    wr_t w;
    for (int b = 0; b < nbytes; b++) begin
      d = next_byte();
      drive_byte(d);
      if (b % 2 == 0) hi = d;
      else begin
        if (m_cap && pix < H && m_row < V) begin
          w.addr = AW'(m_addr);
          w.data = model_rgb(hi, d, pix);
          q_exp.push_back(w);
          m_addr++;
        end
        pix++;
      end
    end
    if (!keep_high) begin
      @(negedge clk);
      cam_href = 1'b0;
      cam_d    = '0;
      repeat (GAP - 1) @(negedge clk);
    end
    if (m_cap && pix > 0) begin
      if (pix != H) m_bad = 1;
      m_row++;
    end
  endtask

  task automatic start_frame(input bit en);
    @(negedge clk);
    cam_vsync = 1'b0;
    enable    = en;
    m_cap     = m_armed && en;
    m_row     = 0;
    m_addr    = 0;
    m_bad     = 0;
    byte_cnt  = 0;
    repeat (3) @(negedge clk);
  endtask

  // VSYNC pulse; mid_line keeps HREF and data running across the rise.
  task automatic end_vsync(input bit mid_line);
    fd_base = fd_cnt;
    exp_fd  = m_cap ? 1 : 0;
    if (m_cap) m_geom = m_bad || (m_row != V);
    @(negedge clk);
    cam_vsync = 1'b1;
    if (mid_line) begin
      cam_href = 1'b1;
      cam_d    = next_byte();
      @(negedge clk);
      cam_d = 8'($urandom);
      @(negedge clk);
    end
    cam_href = 1'b0;
    repeat (4) @(negedge clk);
    m_armed = 1;
    m_cap   = 0;
  endtask

  task automatic check_frame(input string name);
    int n;
    int n_ok = 0;
    bit reported = 0;
    check({name, "_wr_count"}, q_got.size(), q_exp.size());
    n = (q_got.size() < q_exp.size()) ? q_got.size() : q_exp.size();
    for (int i = 0; i < n; i++) begin
      if (q_got[i] === q_exp[i]) n_ok++;
      else if (!reported) begin
        reported = 1;
        check({name, "_wr_addr"}, q_got[i].addr, q_exp[i].addr);
        check({name, "_wr_data"}, q_got[i].data, q_exp[i].data);
      end
    end
    check({name, "_wr_match"}, n_ok, n);
    check({name, "_frame_done"}, fd_cnt - fd_base, exp_fd);
    check({name, "_geom_err"}, geom_err, m_geom);
    q_got.delete();
    q_exp.delete();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int max_addr;
    int rows;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_wren", wren, 1'b0);
    check("reset_wraddress", wraddress, 0);
    check("reset_data", data, 0);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_geom_err", geom_err, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // First VSYNC only arms the block; nothing may be written.
    end_vsync(0);
    check_frame("arm");

    // Nominal frame.
    start_frame(1);
    repeat (V) send_line(2 * H, 0);
    end_vsync(0);
    max_addr = 0;
    foreach (q_got[i]) if (int'(q_got[i].addr) > max_addr) max_addr = int'(q_got[i].addr);
    check("nominal_last_addr", max_addr, H * V - 1);
    check_frame("nominal");

    // Primary-colour expansion.
    fixed_bytes = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F};
    start_frame(1);
    repeat (V) send_line(2 * H, 0);
    end_vsync(0);
    check("expand_red", got_data(0), 24'hFF0000);
    check("expand_green", got_data(1), 24'h00FF00);
    check("expand_blue", got_data(2), 24'h0000FF);
    check_frame("expand");

    // Over-long first line: 321st pixel dropped, next line continues at H.
    start_frame(1);
    send_line(2 * H + 2, 0);
    repeat (V - 1) send_line(2 * H, 0);
    end_vsync(0);
    check("geom_line_end_addr", got_addr(H - 1), H - 1);
    check("geom_next_line_addr", got_addr(H), H);
    check_frame("geometry");

    // Enable low at frame start: no writes.
    start_frame(0);
    repeat (V) send_line(40, 0);
    end_vsync(0);
    check_frame("en_low");

    // Enable drops mid-frame: this frame completes, the next is skipped.
    start_frame(1);
    repeat (3) send_line(2 * H, 0);
    enable = 1'b0;
    repeat (V - 3) send_line(2 * H, 0);
    end_vsync(0);
    check_frame("en_drop");
    start_frame(0);
    repeat (V) send_line(2 * H, 0);
    end_vsync(0);
    check_frame("after_drop");

    // Odd-length line and a frame cut off mid-line.
    start_frame(1);
    send_line(5, 0);
    send_line(2 * H, 0);
    send_line(7, 1);
    end_vsync(1);
    check_frame("odd_early");

    // Reset at pixel 1000 of a frame; rest of that frame must not be written.
    rst_byte = 2000;
    start_frame(1);
    repeat (V) send_line(2 * H, 0);
    rst_byte = -1;
    end_vsync(0);
    check_frame("post_reset");

    // Normal capture resumes after a full VSYNC cycle.
    start_frame(1);
    repeat (V) send_line(2 * H, 0);
    end_vsync(0);
    check_frame("recover");

    // Randomised geometry.
    for (int f = 0; f < 3; f++) begin
      rows = $urandom_range(V + 1, V - 1);
      start_frame(1);
      for (int r = 0; r < rows; r++)
        send_line(($urandom_range(3, 0) == 0) ? $urandom_range(2 * H + 8, 0) : 2 * H, 0);
      end_vsync(0);
      check_frame("random");
    end

`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
    m_tp = 1;
    test_mode = 1'b1;
    start_frame(1);
    repeat (V) send_line(2 * H, 0);
    end_vsync(0);
    check("bar0_white", got_data(0), 24'hFFFFFF);
    check("bar4_magenta", got_data(256), 24'hFF00FF);
    check_frame("pattern");
    m_tp = 0;
    test_mode = 1'b0;
`endif

    check("wren_back_to_back", consec_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
